// File: rtl/std_afifo_wr_arb.sv
// Packet-aware round-robin write-port arbiter for one std_afifo.
// A requester keeps the grant for a whole packet; writes are throttled by the
// FIFO's afull flag, and a requester that stalls mid-packet loses the grant
// after STALL_TIMEOUT idle cycles. Overflow and timeout events are latched in
// sticky flags for software.
module std_afifo_wr_arb #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int IDW           = 2,
  parameter int STALL_TIMEOUT = 255,
  parameter int TO_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic                          fifo_wen,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_afull,
  input  logic                          fifo_overflow,
  output logic                          grant_vld,
  output logic [IDW-1:0]                grant_id,
  input  logic                          clr_sticky,
  output logic                          ovf_sticky,
  output logic                          to_sticky
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IDW-1:0]          rr_ptr_r;
  logic [IDW-1:0]          rr_ptr_nxt_s;
  logic                    grant_vld_r;
  logic                    grant_vld_nxt_s;
  logic [IDW-1:0]          grant_id_r;
  logic [IDW-1:0]          grant_id_nxt_s;
  logic [TO_WIDTH-1:0]     stall_cnt_r;
  logic [TO_WIDTH-1:0]     stall_cnt_nxt_s;
  logic                    fifo_wen_r;
  logic [DATA_WIDTH-1:0]   fifo_wdata_r;
  logic                    ovf_sticky_r;
  logic                    to_sticky_r;

  logic [2*NUM_REQ-1:0]    rot_s;
  logic [IDW-1:0]          sel_s;
  logic [IDW-1:0]          next_ptr_s;
  logic                    any_vld_s;
  logic                    busy_s;
  logic                    cur_vld_s;
  logic                    cur_last_s;
  logic [DATA_WIDTH-1:0]   cur_data_s;
  logic [NUM_REQ-1:0]      req_rdy_s;
  logic                    xfer_s;
  logic                    stall_s;
  logic                    timeout_s;

  assign busy_s     = (state_r == BUSY);
  assign any_vld_s  = |req_vld;
  assign xfer_s     = busy_s && cur_vld_s && !fifo_afull;
  assign stall_s    = busy_s && !cur_vld_s && !fifo_afull;
  assign timeout_s  = stall_s && (stall_cnt_r == TO_WIDTH'(STALL_TIMEOUT - 1));
  assign next_ptr_s = (grant_id_r == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : (grant_id_r + IDW'(1));

  // Circular first-set search starting at rr_ptr; the lowest rotated offset wins.
  always_comb begin : pick_blk
    logic [IDW:0] sum_v;
    rot_s = {req_vld, req_vld} >> rr_ptr_r;
    sel_s = rr_ptr_r;
    sum_v = {(IDW+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_v = {1'b0, rr_ptr_r} + (IDW+1)'(k);
      sum_v = (sum_v >= (IDW+1)'(NUM_REQ)) ? (sum_v - (IDW+1)'(NUM_REQ)) : sum_v;
      sel_s = rot_s[k] ? sum_v[IDW-1:0] : sel_s;
    end
  end

  // Select the granted requester's beat and drive its ready; all others stay low.
  always_comb begin
    cur_vld_s  = 1'b0;
    cur_last_s = 1'b0;
    cur_data_s = {DATA_WIDTH{1'b0}};
    req_rdy_s  = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_r == IDW'(i)) begin
        cur_vld_s    = req_vld[i];
        cur_last_s   = req_last[i];
        cur_data_s   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_rdy_s[i] = busy_s && !fifo_afull;
      end else begin
        req_rdy_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic: grant in IDLE, hold for the packet in BUSY, release on last beat or stall timeout.
  always_comb begin
    state_nxt_s     = state_r;
    grant_vld_nxt_s = grant_vld_r;
    grant_id_nxt_s  = grant_id_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    stall_cnt_nxt_s = stall_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_vld_s) begin
          state_nxt_s     = BUSY;
          grant_vld_nxt_s = 1'b1;
          grant_id_nxt_s  = sel_s;
          stall_cnt_nxt_s = {TO_WIDTH{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (xfer_s) begin
          stall_cnt_nxt_s = {TO_WIDTH{1'b0}};
          if (cur_last_s) begin
            state_nxt_s     = IDLE;
            grant_vld_nxt_s = 1'b0;
            rr_ptr_nxt_s    = next_ptr_s;
          end else begin
            state_nxt_s = BUSY;
          end
        end else if (timeout_s) begin
          state_nxt_s     = IDLE;
          grant_vld_nxt_s = 1'b0;
          rr_ptr_nxt_s    = next_ptr_s;
          stall_cnt_nxt_s = {TO_WIDTH{1'b0}};
        end else if (stall_s) begin
          stall_cnt_nxt_s = stall_cnt_r + TO_WIDTH'(1);
        end else begin
          stall_cnt_nxt_s = stall_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        grant_vld_nxt_s = 1'b0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {IDW{1'b0}};
      grant_vld_r <= 1'b0;
      grant_id_r  <= {IDW{1'b0}};
      stall_cnt_r <= {TO_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      grant_vld_r <= grant_vld_nxt_s;
      grant_id_r  <= grant_id_nxt_s;
      stall_cnt_r <= stall_cnt_nxt_s;
    end
  end

  // One-cycle write pipeline; data holds between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wen_r   <= 1'b0;
      fifo_wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (xfer_s) begin
      fifo_wen_r   <= 1'b1;
      fifo_wdata_r <= cur_data_s;
    end else begin
      fifo_wen_r   <= 1'b0;
      fifo_wdata_r <= fifo_wdata_r;
    end
  end

  // Sticky status flags; a set on the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_r <= 1'b0;
      to_sticky_r  <= 1'b0;
    end else begin
      ovf_sticky_r <= fifo_overflow ? 1'b1 : (clr_sticky ? 1'b0 : ovf_sticky_r);
      to_sticky_r  <= timeout_s     ? 1'b1 : (clr_sticky ? 1'b0 : to_sticky_r);
    end
  end

  assign req_rdy    = req_rdy_s;
  assign fifo_wen   = fifo_wen_r;
  assign fifo_wdata = fifo_wdata_r;
  assign grant_vld  = grant_vld_r;
  assign grant_id   = grant_id_r;
  assign ovf_sticky = ovf_sticky_r;
  assign to_sticky  = to_sticky_r;

endmodule

// File: tb/tb_std_afifo_wr_arb.sv
// Scoreboard bench for std_afifo_wr_arb: a packet-level reference model
// predicts grants and FIFO writes; a separate monitor pops expected writes.
module tb_std_afifo_wr_arb;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;
  localparam int TO  = 8;
  localparam int TOW = 8;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic            fifo_wen;
  logic [DW-1:0]   fifo_wdata;
  logic            fifo_afull;
  logic            fifo_overflow;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic            clr_sticky;
  logic            ovf_sticky;
  logic            to_sticky;

  std_afifo_wr_arb #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .IDW(IDW), .STALL_TIMEOUT(TO), .TO_WIDTH(TOW)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_last(req_last), .req_data(req_data),
    .req_rdy(req_rdy), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .fifo_afull(fifo_afull), .fifo_overflow(fifo_overflow), .grant_vld(grant_vld),
    .grant_id(grant_id), .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky),
    .to_sticky(to_sticky)
  );

  always #5 clk = ~clk;

  // stimulus state: per-requester beat lists and read positions
  beat_t bq [N][$];
  int    pos [N];
  int    pstart [N];
  bit    en [N];
  bit    afull_n, ovf_n, clr_n, rst_req;

  // reference model state
  bit    m_busy;
  int    m_gid, m_ptr, m_stall;
  bit    m_ovf, m_to;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_wdata;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.last = (k == len - 1);
      b.data = $urandom;
      bq[r].push_back(b);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (pos[i] < bq[i].size()) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_stall = 0; m_ovf = 1'b0; m_to = 1'b0;
    exp_q.delete();
    last_wdata = '0;
    for (int i = 0; i < N; i++) pos[i] = pstart[i];
  endtask

  // packet-level rules applied once per clock edge
  task automatic model_step();
    bit to_evt = 1'b0;
    bit found  = 1'b0;
    bit lst;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_vld[(m_ptr + k) % N]) begin
          found = 1'b1; m_gid = (m_ptr + k) % N; m_busy = 1'b1; m_stall = 0;
        end
      end
    end else if (req_vld[m_gid] && !fifo_afull) begin
      exp_q.push_back(bq[m_gid][pos[m_gid]].data);
      lst = bq[m_gid][pos[m_gid]].last;
      pos[m_gid]++;
      m_stall = 0;
      if (lst) begin
        pstart[m_gid] = pos[m_gid];
        m_busy = 1'b0;
        m_ptr = (m_gid + 1) % N;
      end
    end else if (!fifo_afull) begin
      m_stall++;
      if (m_stall == TO) begin
        m_busy = 1'b0; m_ptr = (m_gid + 1) % N; m_stall = 0; to_evt = 1'b1;
      end
    end
    m_ovf = fifo_overflow ? 1'b1 : (clr_sticky ? 1'b0 : m_ovf);
    m_to  = to_evt        ? 1'b1 : (clr_sticky ? 1'b0 : m_to);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && pos[i] < bq[i].size()) begin
        req_vld[i] = 1'b1;
        req_last[i] = bq[i][pos[i]].last;
        req_data[i*DW +: DW] = bq[i][pos[i]].data;
      end else begin
        req_vld[i] = 1'b0;
        req_last[i] = 1'($urandom_range(0, 1));
        req_data[i*DW +: DW] = $urandom;
      end
    end
    fifo_afull = afull_n;
    fifo_overflow = ovf_n;
    clr_sticky = clr_n;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    #1;
    chk("grant_vld", 64'(grant_vld), 64'(m_busy));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_ovf));
    chk("to_sticky", 64'(to_sticky), 64'(m_to));
    drive_inputs();
    ovf_n = 1'b0;
    clr_n = 1'b0;
    if (rst_req) begin
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst fifo_wen", 64'(fifo_wen), 64'd0);
      chk("rst fifo_wdata", 64'(fifo_wdata), 64'd0);
      chk("rst grant_vld", 64'(grant_vld), 64'd0);
      chk("rst grant_id", 64'(grant_id), 64'd0);
      chk("rst req_rdy", 64'(req_rdy), 64'd0);
      chk("rst stickies", 64'({ovf_sticky, to_sticky}), 64'd0);
    end else begin
      rst = 1'b0;
      #1;
      exp_rdy = '0;
      if (m_busy && !fifo_afull) exp_rdy[m_gid] = 1'b1;
      chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((pending() || m_busy) && c < budget) begin
      cycle();
      c++;
    end
    n_checks++;
    if (c >= budget) begin
      n_errs++;
      $display("FAIL drain: cycle budget %0d expired, pending work remains", budget);
    end
    cycle();
    cycle();
  endtask

  // monitor: every write must match the next expected beat, one cycle after its transfer
  always @(negedge clk) begin
    logic [DW-1:0] d;
    if (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      chk("fifo_wen", 64'(fifo_wen), 64'd1);
      chk("fifo_wdata", 64'(fifo_wdata), 64'(d));
      last_wdata = d;
    end else begin
      chk("fifo_wen idle", 64'(fifo_wen), 64'd0);
      chk("fifo_wdata hold", 64'(fifo_wdata), 64'(last_wdata));
    end
  end

  initial begin
    rst = 1'b1;
    req_vld = '0; req_last = '0; req_data = '0;
    fifo_afull = 1'b0; fifo_overflow = 1'b0; clr_sticky = 1'b0;
    afull_n = 1'b0; ovf_n = 1'b0; clr_n = 1'b0; rst_req = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1; pos[i] = 0; pstart[i] = 0;
    end
    model_reset();
    repeat (3) cycle();

    // requesters 0 and 2 hold 3-beat packets from reset release
    add_pkt(0, 3);
    add_pkt(2, 3);
    rst_req = 1'b0;
    repeat (12) cycle();

    // all requesters: four single-beat packets each
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < N; i++) add_pkt(i, 1);
    drain(200);

    // afull held for 10 cycles mid-packet of requester 1
    add_pkt(1, 6);
    repeat (4) cycle();
    afull_n = 1'b1;
    repeat (10) cycle();
    afull_n = 1'b0;
    drain(100);

    // requester 3 stalls mid-packet until the grant times out
    add_pkt(3, 5);
    add_pkt(0, 2);
    repeat (3) cycle();
    en[3] = 1'b0;
    repeat (12) cycle();
    clr_n = 1'b1;
    cycle();
    repeat (2) cycle();
    pos[3] = bq[3].size();
    pstart[3] = pos[3];
    en[3] = 1'b1;
    drain(100);

    // reset pulse mid-packet of requester 2; packet re-sent from its start
    add_pkt(2, 6);
    repeat (3) cycle();
    add_pkt(0, 2);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    drain(100);

    // overflow together with clear, then a clear alone
    ovf_n = 1'b1;
    clr_n = 1'b1;
    cycle();
    repeat (2) cycle();
    clr_n = 1'b1;
    cycle();
    repeat (2) cycle();

    // randomized traffic with bubbles, backpressure and sticky events
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        en[i] = ($urandom_range(0, 3) != 0);
        if ((bq[i].size() - pos[i]) < 2 && $urandom_range(0, 3) == 0)
          add_pkt(i, $urandom_range(1, 5));
      end
      afull_n = ($urandom_range(0, 7) == 0);
      ovf_n   = ($urandom_range(0, 31) == 0);
      clr_n   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    afull_n = 1'b0;
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/std_afifo_wr_arb.md
Name: std_afifo_wr_arb

Overview:
- Packet-aware round-robin arbiter that shares the single write port of one std_afifo among NUM_REQ requesters in the write-clock domain.
- Grants a requester for a whole packet, so packets from different requesters never interleave.
- Throttles writes with the FIFO's afull (prog_full) flag.
- Releases a grant when a requester stalls mid-packet for too long, and keeps sticky status flags for software.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, beat width; equals the std_afifo WRITE_DATA_WIDTH.
- IDW, 2, grant index width; must be at least clog2(NUM_REQ).
- STALL_TIMEOUT, 255, number of consecutive idle grant cycles, with afull low, before the grant is forcibly released.
- TO_WIDTH, 8, stall counter width; must hold STALL_TIMEOUT.

Ports:
- clk  input  1  write-domain clock, same clock as std_afifo wrclk
- rst  input  1  asynchronous, active-high reset
- req_vld  input  NUM_REQ  per-requester beat valid
- req_last  input  NUM_REQ  per-requester end-of-packet marker, qualified by req_vld
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_rdy  output  NUM_REQ  per-requester beat accept
- fifo_wen  output  1  to std_afifo wen
- fifo_wdata  output  DATA_WIDTH  to std_afifo wdata
- fifo_afull  input  1  from std_afifo afull
- fifo_overflow  input  1  from std_afifo overflow
- grant_vld  output  1  a packet grant is active
- grant_id  output  IDW  index of the granted requester
- clr_sticky  input  1  single-cycle clear of the sticky flags
- ovf_sticky  output  1  latched fifo_overflow
- to_sticky  output  1  latched stall-timeout event

Behaviour:
- Reset: while rst is high, the following are all 0: state=IDLE, rr_ptr, grant_vld, grant_id, fifo_wen, fifo_wdata, stall counter, ovf_sticky, to_sticky.
  - req_rdy is 0 throughout reset because it is derived from state.
  - An in-flight packet is abandoned. Requesters must re-send it from its start.
- State machine: two states, IDLE and BUSY.
  - IDLE: if any req_vld bit is set, select the first set bit scanning circularly from rr_ptr. Then grant_id<=sel, grant_vld<=1, go to BUSY.
  - The grant decision costs one cycle, so there is at least one idle cycle between packets.
  - IDLE with no req_vld set: stay in IDLE.
- req_rdy[i] = (state==BUSY) && (grant_id==i) && !fifo_afull. This is combinational. No other bit of req_rdy is ever 1.
- Transfer: xfer = req_vld[grant_id] && req_rdy[grant_id].
  - On xfer, next cycle: fifo_wen=1 and fifo_wdata=the granted requester's beat. Latency is exactly 1 cycle.
  - fifo_wen is 0 on every cycle not preceded by an xfer.
  - fifo_wdata holds its last value when fifo_wen=0.
- Packet end: xfer with req_last=1 causes state<=IDLE, grant_vld<=0, rr_ptr<=(grant_id+1) mod NUM_REQ.
- Backpressure: while fifo_afull=1, no beats are accepted and the grant is held.
  - The std_afifo PROG_FULL_THRESH slack of at least 8 entries absorbs the 1-cycle pipeline plus afull assertion latency.
  - This block never writes while the FIFO is full, provided the slack is at least 4.
- Stall timeout:
  - In BUSY, the counter increments on each cycle with !req_vld[grant_id] && !fifo_afull.
  - It resets to 0 on xfer, and holds while fifo_afull=1.
  - When it reaches STALL_TIMEOUT: release the grant (state<=IDLE, grant_vld<=0), set rr_ptr past grant_id, set to_sticky, clear the counter.
  - The partial packet already in the FIFO is not repaired. The downstream reader detects it through to_sticky.
- Sticky flags:
  - ovf_sticky is set on any cycle with fifo_overflow=1.
  - A set on the same cycle as clr_sticky wins over the clear, for both sticky flags.
- Simultaneous events: a req_vld arriving on the same cycle as a grant release is considered in the next IDLE cycle.
- Single-beat packets: a packet with req_last on its first beat is legal.
- NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0. Indices at or above NUM_REQ are never granted.

Test Plan:
- Requesters 0 and 2 each hold a 3-beat packet from reset release -> grant 0 first; 3 fifo_wen pulses with 0's data; 1 idle cycle; grant_id=2; 3 pulses; rr_ptr=3.
- All 4 requesters issue continuous 1-beat packets for 16 packets -> grant_id sequence 0,1,2,3 repeating; exactly 4 beats per requester; no beat ever has fifo_wen asserted without a preceding xfer.
- fifo_afull raised for 10 cycles mid-packet of requester 1 -> req_rdy=0 for those cycles; fifo_wen=0 from the cycle after afull rises; grant_id stays 1; the packet resumes with no lost or duplicated beats.
- Granted requester 3 drops req_vld mid-packet with STALL_TIMEOUT=8 -> after 8 stall cycles grant_vld=0 and to_sticky=1; the next grant goes to 0; clr_sticky clears to_sticky.
- rst pulsed for 1 cycle mid-packet of requester 2 -> all outputs 0 immediately; after release, arbitration restarts from rr_ptr=0.
- fifo_overflow pulsed on the same cycle as clr_sticky -> ovf_sticky=1 afterwards; a later clr_sticky alone -> ovf_sticky=0.
